conv_mac_pipe: RTL and testbench

Pipelined, multi-channel successor to the single-vector conv dot-product core. Each accepted beat is one VEC_LEN-element image/kernel vector pair for one input channel. IN_CH consecutive beats are accumulated with a bias, then passed through optional ReLU, a rounding right-shift and saturation to an OUT_W activation. Sits between the window/line-buffer streamer and the output feature-map writer, with valid/ready on both sides.

---
 rtl/conv_pkg.sv | 20 ++
 rtl/conv_mac_pipe_mac_tree.sv | 58 +++++
 rtl/conv_mac_pipe.sv | 125 ++++++++++++
 tb/tb_conv_mac_pipe.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants and helpers for the conv MAC pipeline family.
// Default widths, clog2 and activation saturation bounds.
package conv_pkg;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_VEC_LEN = 9;
  localparam int DEF_ACC_W   = 32;
  localparam int DEF_OUT_W   = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

  localparam logic signed [DEF_OUT_W-1:0] SAT_MAX =
    DEF_OUT_W'((1 << (DEF_OUT_W - 1)) - 1);
  localparam logic signed [DEF_OUT_W-1:0] SAT_MIN =
    DEF_OUT_W'(-(1 << (DEF_OUT_W - 1)));
endpackage

// File: rtl/conv_mac_pipe_mac_tree.sv
// Two-stage dot product: registered products, then registered sum.
// A side tag travels alongside the valid bit.
module mac_tree
  import conv_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int VEC_LEN = DEF_VEC_LEN,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int TAG_W   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      in_valid,
  input  logic [TAG_W-1:0]          in_tag,
  input  logic [DATA_W*VEC_LEN-1:0] img,
  input  logic [DATA_W*VEC_LEN-1:0] ker,
  output logic                      out_valid,
  output logic [TAG_W-1:0]          out_tag,
  output logic signed [ACC_W-1:0]   out_sum
);
  logic signed [2*DATA_W-1:0] r_prod [VEC_LEN];
  logic                       r_v1;
  logic [TAG_W-1:0]           r_tag1;
  logic signed [ACC_W-1:0]    w_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_tag1 <= '0;
      for (int i = 0; i < VEC_LEN; i++) r_prod[i] <= '0;
    end else if (en) begin
      r_v1   <= in_valid;
      r_tag1 <= in_tag;
      for (int i = 0; i < VEC_LEN; i++)
        r_prod[i] <= $signed(img[i*DATA_W +: DATA_W])
                   * $signed(ker[i*DATA_W +: DATA_W]);
    end
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < VEC_LEN; i++)
      w_sum = w_sum + ACC_W'(r_prod[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_tag   <= '0;
      out_sum   <= '0;
    end else if (en) begin
      out_valid <= r_v1;
      out_tag   <= r_tag1;
      out_sum   <= w_sum;
    end
  end
endmodule

// File: rtl/conv_mac_pipe.sv
// Multi-channel conv MAC: accumulate IN_CH beats plus bias,
// then ReLU, rounding shift and saturation to OUT_W.
module conv_mac_pipe
  import conv_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int VEC_LEN = DEF_VEC_LEN,
  parameter int IN_CH   = 3,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int BIAS_W  = 32,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int SHIFT_W = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W*VEC_LEN-1:0] img_vec,
  input  logic [DATA_W*VEC_LEN-1:0] ker_vec,
  input  logic [BIAS_W-1:0]         bias,
  input  logic                      relu_en,
  input  logic [SHIFT_W-1:0]        shift,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_W-1:0]          out_data,
  output logic [ACC_W-1:0]          out_acc
);
  localparam int CNT_W = (IN_CH > 1) ? clog2(IN_CH) : 1;
  localparam int TAG_W = BIAS_W + 2;
  localparam logic signed [ACC_W:0] SAT_HI =
    (ACC_W+1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W:0] SAT_LO =
    (ACC_W+1)'(-(1 << (OUT_W - 1)));

  logic                    w_en;
  logic                    w_acc_in;
  logic                    w_first;
  logic                    w_last;
  logic [CNT_W-1:0]        r_cnt;
  logic                    w_v2;
  logic [TAG_W-1:0]        w_tag2;
  logic signed [ACC_W-1:0] w_sum2;
  logic signed [ACC_W-1:0] w_bias2;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_v3;
  logic signed [ACC_W-1:0] w_v;
  logic signed [ACC_W:0]   w_vx;
  logic signed [ACC_W:0]   w_half;
  logic signed [ACC_W:0]   w_r;
  logic [OUT_W-1:0]        w_sat;
  logic                    r_out_valid;
  logic [OUT_W-1:0]        r_out_data;
  logic [ACC_W-1:0]        r_out_acc;

  assign w_en     = !r_out_valid || out_ready;
  assign in_ready = w_en;
  assign w_acc_in = in_valid && w_en;
  assign w_first  = (r_cnt == '0);
  assign w_last   = (r_cnt == CNT_W'(IN_CH - 1));

  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else if (w_acc_in) r_cnt <= w_last ? '0 : r_cnt + 1'b1;
  end

  mac_tree #(
    .DATA_W (DATA_W),
    .VEC_LEN(VEC_LEN),
    .ACC_W  (ACC_W),
    .TAG_W  (TAG_W)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .en       (w_en),
    .in_valid (in_valid),
    .in_tag   ({bias, w_first, w_last}),
    .img      (img_vec),
    .ker      (ker_vec),
    .out_valid(w_v2),
    .out_tag  (w_tag2),
    .out_sum  (w_sum2)
  );

  assign w_bias2 = ACC_W'($signed(w_tag2[TAG_W-1:2]));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_v3  <= 1'b0;
    end else if (w_en) begin
      r_v3 <= w_v2 && w_tag2[0];
      if (w_v2)
        r_acc <= w_tag2[1] ? w_bias2 + w_sum2 : r_acc + w_sum2;
    end
  end

  // Widened by one bit so the rounding offset cannot wrap.
  always_comb begin
    w_v    = (relu_en && r_acc[ACC_W-1]) ? '0 : r_acc;
    w_vx   = {w_v[ACC_W-1], w_v};
    w_half = {{ACC_W{1'b0}}, 1'b1} << (shift - 1'b1);
    w_r    = (shift != '0) ? (w_vx + w_half) >>> shift : w_vx;
    if (w_r > SAT_HI)      w_sat = SAT_HI[OUT_W-1:0];
    else if (w_r < SAT_LO) w_sat = SAT_LO[OUT_W-1:0];
    else                   w_sat = w_r[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_acc   <= '0;
    end else if (w_en) begin
      r_out_valid <= r_v3;
      if (r_v3) begin
        r_out_data <= w_sat;
        r_out_acc  <= r_acc;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_acc   = r_out_acc;
endmodule

// File: tb/tb_conv_mac_pipe.sv
// Directed bench for conv_mac_pipe: vector table plus
// backpressure and mid-group reset sequences.
module tb_conv_mac_pipe;
  localparam int DW = 8;
  localparam int VL = 9;
  localparam int NC = 3;
  localparam int AW = 32;
  localparam int BW = 32;
  localparam int OW = 8;
  localparam int SW = 5;

  logic              clk = 0;
  logic              rst = 1;
  logic              in_valid = 0;
  logic              in_ready;
  logic [DW*VL-1:0]  img_vec = '0;
  logic [DW*VL-1:0]  ker_vec = '0;
  logic [BW-1:0]     bias = '0;
  logic              relu_en = 0;
  logic [SW-1:0]     shift = '0;
  logic              out_valid;
  logic              out_ready = 1;
  logic [OW-1:0]     out_data;
  logic [AW-1:0]     out_acc;

  int checks = 0;
  int errors = 0;

  conv_mac_pipe #(
    .DATA_W(DW), .VEC_LEN(VL), .IN_CH(NC), .ACC_W(AW),
    .BIAS_W(BW), .OUT_W(OW), .SHIFT_W(SW)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .img_vec(img_vec), .ker_vec(ker_vec), .bias(bias),
    .relu_en(relu_en), .shift(shift), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_acc(out_acc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int img; int ker; int bias; bit relu; int sh;
    int exp_acc; int exp_data;
  } vec_t;

  vec_t tv[9];

  task automatic check(input string name, input longint act,
                       input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send_beat(input int a, input int b, input int bs);
    bit ok;
    logic [7:0] ea, eb;
    ea = a[7:0];
    eb = b[7:0];
    for (int i = 0; i < VL; i++) begin
      img_vec[i*DW +: DW] = ea;
      ker_vec[i*DW +: DW] = eb;
    end
    bias = bs;
    in_valid = 1;
    ok = 0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) check("send_timeout", 0, 1);
  endtask

  int n;
  int got_data[$];
  int got_acc[$];
  bit held_v;
  int held_d;
  int nout;

  initial begin
    tv[0] = '{1, 1, 0, 0, 0, 27, 27};
    tv[1] = '{-128, -128, 0, 0, 0, 442368, 127};
    tv[2] = '{-128, -128, 0, 0, 12, 442368, 108};
    tv[3] = '{1, -1, 0, 0, 0, -27, -27};
    tv[4] = '{1, -1, 0, 1, 0, -27, 0};
    tv[5] = '{0, 0, 5, 0, 1, 5, 3};
    tv[6] = '{0, 0, -5, 0, 1, -5, -2};
    tv[7] = '{0, 0, 1000, 0, 2, 1000, 127};
    tv[8] = '{0, 0, -1000, 0, 2, -1000, -128};

    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_acc", out_acc, 0);
    check("rst_in_ready", in_ready, 1);

    for (int t = 0; t < 9; t++) begin
      relu_en = tv[t].relu;
      shift = SW'(tv[t].sh);
      for (int b = 0; b < NC; b++)
        send_beat(tv[t].img, tv[t].ker,
                  b == 0 ? tv[t].bias : tv[t].bias + 77);
      in_valid = 0;
      n = 0;
      do begin
        @(posedge clk);
        #1;
        n++;
      end while (!out_valid && n < 20);
      check($sformatf("latency_%0d", t), n, 3);
      check($sformatf("acc_%0d", t), $signed(out_acc), tv[t].exp_acc);
      check($sformatf("data_%0d", t), $signed(out_data),
            tv[t].exp_data);
      @(posedge clk);
      #1;
      check($sformatf("drop_%0d", t), out_valid, 0);
    end

    relu_en = 0;
    shift = '0;
    held_v = 0;
    held_d = 0;
    fork
      begin
        for (int g = 0; g < 4; g++)
          for (int b = 0; b < NC; b++)
            send_beat(1, 1, b == 0 ? g * 10 : 999);
        in_valid = 0;
      end
      begin
        for (int cyc = 1; cyc <= 60; cyc++) begin
          @(posedge clk);
          #2;
          out_ready = !(cyc >= 8 && cyc < 13);
          @(negedge clk);
          if (held_v) begin
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_data", out_data, held_d);
          end
          if (out_valid && !out_ready)
            check("bp_in_ready_low", in_ready, 0);
          if (out_valid && out_ready) begin
            got_data.push_back(int'($signed(out_data)));
            got_acc.push_back(int'($signed(out_acc)));
          end
          held_v = out_valid && !out_ready;
          held_d = int'(out_data);
        end
        out_ready = 1;
      end
    join
    check("bp_count", got_data.size(), 4);
    for (int g = 0; g < 4 && g < got_data.size(); g++) begin
      check($sformatf("bp_data_%0d", g), got_data[g], 27 + 10 * g);
      check($sformatf("bp_acc_%0d", g), got_acc[g], 27 + 10 * g);
    end

    send_beat(1, 1, 100);
    send_beat(1, 1, 100);
    in_valid = 0;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    check("rst2_out_valid", out_valid, 0);
    for (int b = 0; b < NC; b++) send_beat(1, 1, 0);
    in_valid = 0;
    nout = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (out_valid) begin
        nout++;
        check("rst2_data", $signed(out_data), 27);
        check("rst2_acc", $signed(out_acc), 27);
      end
    end
    check("rst2_count", nout, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
